xgmii_link_fault_rs: RTL and testbench



---
 rtl/xgmii_link_fault_rs.sv | 133 +++++++++++++
 tb/tb_xgmii_link_fault_rs.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/xgmii_link_fault_rs.sv
// XGMII reconciliation-sublayer link fault handler: RX fault detection, TX fault response.
// Fault state updates on the edge sampling the column; TX is a 1-cycle registered mux; no backpressure.
module xgmii_link_fault_rs #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = (DATA_WIDTH/8),
  parameter int SEQ_CNT_LIMIT = 4,
  parameter int COL_CNT_LIMIT = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  input  logic [DATA_WIDTH-1:0] mac_txd,
  input  logic [CTRL_WIDTH-1:0] mac_txc,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic [1:0]            link_fault,
  output logic                  link_up,
  output logic [15:0]           fault_count
);

  localparam int SEQ_W = $clog2(SEQ_CNT_LIMIT + 1);
  localparam int COL_W = $clog2(COL_CNT_LIMIT + 1);

  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SEQ_CNT_LIMIT);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_CNT_LIMIT);

  localparam logic [DATA_WIDTH-1:0] IDLE_DAT = 64'h0707070707070707;
  localparam logic [CTRL_WIDTH-1:0] IDLE_CTL = 8'hFF;
  localparam logic [DATA_WIDTH-1:0] RFLT_DAT = 64'h0200009C_0200009C;
  localparam logic [CTRL_WIDTH-1:0] RFLT_CTL = 8'h11;

  // LF_OK doubles as "no sequence type seen" for last_type.
  typedef enum logic [1:0] {
    LF_OK     = 2'b00,
    LF_LOCAL  = 2'b01,
    LF_REMOTE = 2'b10
  } fault_e;

  typedef struct packed {
    fault_e           lf;
    fault_e           last;
    logic [SEQ_W-1:0] seq;
    logic [COL_W-1:0] col;
  } rx_st_t;

  function automatic fault_e col_type(input logic [31:0] d, input logic [3:0] c);
    fault_e t;
    t = LF_OK;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
      if (d[31:24] == 8'h01)      t = LF_LOCAL;
      else if (d[31:24] == 8'h02) t = LF_REMOTE;
    end
    return t;
  endfunction

  // A non-sequence column only clears col-side state; a partial seq run survives it.
  function automatic rx_st_t col_step(input rx_st_t s, input fault_e t);
    rx_st_t n;
    n = s;
    if (t != LF_OK) begin
      n.col = '0;
      if (t == s.last) begin
        if (s.seq < SEQ_MAX) n.seq = s.seq + SEQ_W'(1);
      end else begin
        n.seq  = SEQ_W'(1);
        n.last = t;
      end
      if (n.seq == SEQ_MAX) n.lf = t;
    end else begin
      if (s.col < COL_MAX) n.col = s.col + COL_W'(1);
      if (n.col == COL_MAX) begin
        n.lf   = LF_OK;
        n.seq  = '0;
        n.last = LF_OK;
      end
    end
    return n;
  endfunction

  rx_st_t                rx_q, rx_d, rx_mid;
  logic [15:0]           fault_cnt_q, fault_cnt_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic [CTRL_WIDTH-1:0] txc_q, txc_d;

  always_comb begin
    rx_mid = col_step(rx_q,   col_type(xgmii_rxd[31:0],  xgmii_rxc[3:0]));
    rx_d   = col_step(rx_mid, col_type(xgmii_rxd[63:32], xgmii_rxc[7:4]));

    fault_cnt_d = fault_cnt_q;
    if (rx_q.lf == LF_OK && rx_d.lf != LF_OK && fault_cnt_q != 16'hFFFF)
      fault_cnt_d = fault_cnt_q + 16'd1;

    // Mode changes cut the MAC stream on a word boundary without inserting a terminate.
    txd_d = IDLE_DAT;
    txc_d = IDLE_CTL;
    case (rx_q.lf)
      LF_OK: begin
        txd_d = mac_txd;
        txc_d = mac_txc;
      end
      LF_LOCAL: begin
        txd_d = RFLT_DAT;
        txc_d = RFLT_CTL;
      end
      default: begin
        txd_d = IDLE_DAT;
        txc_d = IDLE_CTL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q        <= '{lf: LF_OK, last: LF_OK, seq: '0, col: '0};
      fault_cnt_q <= '0;
      txd_q       <= IDLE_DAT;
      txc_q       <= IDLE_CTL;
    end else begin
      rx_q        <= rx_d;
      fault_cnt_q <= fault_cnt_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
    end
  end

  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign link_fault  = rx_q.lf;
  assign link_up     = (rx_q.lf == LF_OK);
  assign fault_count = fault_cnt_q;

endmodule

// File: tb/tb_xgmii_link_fault_rs.sv
// Directed bench for xgmii_link_fault_rs; expected TX words queued at drive time, popped after the edge.
module tb_xgmii_link_fault_rs;

  localparam logic [63:0] IDLE_W   = 64'h0707070707070707;
  localparam logic [63:0] LF_W     = 64'h0100009C_0100009C;
  localparam logic [63:0] RF_W     = 64'h0200009C_0200009C;
  localparam logic [31:0] LF_COL   = 32'h0100009C;
  localparam logic [31:0] RF_COL   = 32'h0200009C;
  localparam logic [31:0] IDLE_COL = 32'h07070707;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] xgmii_rxd, mac_txd, xgmii_txd;
  logic [7:0]  xgmii_rxc, mac_txc, xgmii_txc;
  logic [1:0]  link_fault;
  logic        link_up;
  logic [15:0] fault_count;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
  } tx_t;

  tx_t        sb[$];
  logic [1:0] exp_lf;
  int         n_cmp = 0;
  int         n_bad = 0;

  xgmii_link_fault_rs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xgmii_rxd  (xgmii_rxd),
    .xgmii_rxc  (xgmii_rxc),
    .mac_txd    (mac_txd),
    .mac_txc    (mac_txc),
    .xgmii_txd  (xgmii_txd),
    .xgmii_txc  (xgmii_txc),
    .link_fault (link_fault),
    .link_up    (link_up),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word: drive at negedge, queue the TX word implied by the fault state before
  // this edge, then compare after the edge. lf_after is the fault state this word produces.
  task automatic cyc(input logic [63:0] rd, input logic [7:0] rc,
                     input logic [63:0] md, input logic [7:0] mc,
                     input logic [1:0] lf_after);
    tx_t e;
    @(negedge clk);
    xgmii_rxd = rd;
    xgmii_rxc = rc;
    mac_txd   = md;
    mac_txc   = mc;
    case (exp_lf)
      2'b00:   e = '{d: md,     c: mc};
      2'b01:   e = '{d: RF_W,   c: 8'h11};
      default: e = '{d: IDLE_W, c: 8'hFF};
    endcase
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("txd", xgmii_txd, e.d);
    check("txc", {56'd0, xgmii_txc}, {56'd0, e.c});
    check("link_fault", {62'd0, link_fault}, {62'd0, lf_after});
    check("link_up", {63'd0, link_up}, {63'd0, (lf_after == 2'b00)});
    exp_lf = lf_after;
  endtask

  task automatic idle_words(input int n, input logic [1:0] lf_after);
    for (int i = 0; i < n; i++)
      cyc(IDLE_W, 8'hFF, {$urandom, $urandom}, 8'h00, lf_after);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_txd"}, xgmii_txd, IDLE_W);
    check({tag, "_txc"}, {56'd0, xgmii_txc}, 64'hFF);
    check({tag, "_lf"}, {62'd0, link_fault}, 64'd0);
    check({tag, "_up"}, {63'd0, link_up}, 64'd1);
    check({tag, "_fc"}, {48'd0, fault_count}, 64'd0);
  endtask

  initial begin
    xgmii_rxd = IDLE_W;
    xgmii_rxc = 8'hFF;
    mac_txd   = 64'd0;
    mac_txc   = 8'h00;
    exp_lf    = 2'b00;

    // Reset values while reset is held.
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // MAC pass-through with idle RX.
    cyc(IDLE_W, 8'hFF, 64'h1122334455667788, 8'h00, 2'b00);
    cyc(IDLE_W, 8'hFF, 64'hDEADBEEFCAFEF00D, 8'h0F, 2'b00);

    // Four local-fault columns over two words.
    cyc(LF_W, 8'h11, 64'h0123456789ABCDEF, 8'h00, 2'b00);
    cyc(LF_W, 8'h11, 64'h0123456789ABCDEF, 8'h00, 2'b01);
    check("fc_local", {48'd0, fault_count}, 64'd1);

    // 126 idle columns keep the fault, the 128th clears it.
    idle_words(63, 2'b01);
    idle_words(1, 2'b00);
    cyc(IDLE_W, 8'hFF, 64'h5555AAAA5555AAAA, 8'h00, 2'b00);
    check("fc_after_clear", {48'd0, fault_count}, 64'd1);

    // Remote fault: TX answers with idles while the MAC sends data.
    cyc(RF_W, 8'h11, 64'hAABBCCDDEEFF0011, 8'h00, 2'b00);
    cyc(RF_W, 8'h11, 64'hAABBCCDDEEFF0011, 8'h00, 2'b10);
    cyc(IDLE_W, 8'hFF, 64'hAABBCCDDEEFF0011, 8'h00, 2'b10);
    check("fc_remote", {48'd0, fault_count}, 64'd2);
    idle_words(62, 2'b10);
    idle_words(1, 2'b00);

    // Alternating local/remote columns never accumulate a run.
    for (int i = 0; i < 100; i++)
      cyc({RF_COL, LF_COL}, 8'h11, {$urandom, $urandom}, 8'h00, 2'b00);

    // Non-sequence column between local columns keeps the run.
    cyc({LF_COL, LF_COL}, 8'h11, 64'h1, 8'h00, 2'b00);
    cyc({IDLE_COL, LF_COL}, 8'hF1, 64'h2, 8'h00, 2'b00);
    cyc({IDLE_COL, LF_COL}, 8'hF1, 64'h3, 8'h00, 2'b01);
    check("fc_gap_run", {48'd0, fault_count}, 64'd3);

    // Direct local-to-remote switch does not count as a new fault.
    cyc(RF_W, 8'h11, 64'h4, 8'h00, 2'b01);
    cyc(RF_W, 8'h11, 64'h5, 8'h00, 2'b10);
    check("fc_switch", {48'd0, fault_count}, 64'd3);

    // Asynchronous reset mid-fault.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_lf = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A single local column after reset does not fault.
    cyc({IDLE_COL, LF_COL}, 8'hF1, 64'h9988776655443322, 8'h00, 2'b00);
    cyc(IDLE_W, 8'hFF, 64'h1020304050607080, 8'h00, 2'b00);
    check("fc_post_rst", {48'd0, fault_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
